pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised successor to the plain enabled pipeline register. Adds a valid/ready handshake on both sides, a synchronous flush, and an optional two-entry skid buffer that fully registers upstream ready. Also keeps a saturating stall counter. Sits between processor pipeline stages (IF/ID/EX/MEM/WB) so that back-pressure and branch flushes propagate without combinational ready chains.

Parameters:
DATA_WIDTH, 32, width of one lane in bits
NUM_REG, 1, number of lanes packed into the payload
SKID_EN, 1, 1 = two-entry skid buffer with registered o_ready; 0 = single register with pass-through ready
CNT_WIDTH, 16, width of the stall counter

Ports:
clk  in  1  clock, all state updates on its rising edge
rst_n  in  1  synchronous, active-low reset
i_flush  in  1  discard all held entries; has priority over every other event
i_valid  in  1  upstream payload valid
o_ready  out  1  stage can accept a payload this cycle
i_data  in  NUM_REG*DATA_WIDTH  upstream payload
o_valid  out  1  downstream payload valid
i_ready  in  1  downstream accepts this cycle
o_data  out  NUM_REG*DATA_WIDTH  downstream payload, always taken from the main register
o_occupancy  out  2  entries held: 0, 1 or 2
o_stall_count  out  CNT_WIDTH  cycles with o_valid=1 and i_ready=0, saturating

Behaviour:
- Definitions: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- Reset (rst_n=0 at a clock edge): state EMPTY; main data, skid data and o_stall_count go to 0; o_valid=0; o_occupancy=0.
  - o_ready while rst_n=0: 0 when SKID_EN=1; i_ready when SKID_EN=0.
  - Reset mid-transfer drops all held entries; no payload is emitted.
- States (SKID_EN=1): EMPTY, FULL (main only), SKID (main plus skid).
  - o_valid = (state != EMPTY).
  - o_ready = (state != SKID), a pure function of registered state.
  - o_occupancy = 0/1/2 for EMPTY/FULL/SKID.
- Transitions (SKID_EN=1), evaluated when i_flush=0:
  - EMPTY: in_fire -> FULL, main <= i_data. Otherwise stay.
  - FULL: in_fire & out_fire -> FULL, main <= i_data.
  - FULL: in_fire & !out_fire -> SKID, skid <= i_data, main unchanged.
  - FULL: !in_fire & out_fire -> EMPTY.
  - FULL: neither -> hold.
  - SKID: out_fire -> FULL, main <= skid. in_fire is impossible (o_ready=0). Otherwise hold.
- SKID_EN=0:
  - States EMPTY/FULL only; skid register is not instantiated.
  - o_ready = i_ready | ~o_valid (combinational).
  - Same EMPTY/FULL transitions as above.
- Latency: 1 cycle from in_fire to o_valid when the stage is empty. Throughput is 1 per cycle in both modes.
- Flush (i_flush=1 at a clock edge): next state EMPTY regardless of in_fire/out_fire.
  - An out_fire in the flush cycle counts as delivered.
  - An in_fire in the flush cycle is discarded.
  - Data registers are not cleared; only validity is.
  - o_ready=1 the following cycle.
- Data stability: o_data and o_valid stay unchanged while o_valid=1 and i_ready=0, except on flush.
- Stall counter:
  - Increments when o_valid & ~i_ready (sampled before flush is applied).
  - Saturates at 2^CNT_WIDTH-1.
  - Cleared only by reset.
- No X-propagation: all outputs are driven from registers or from defined combinational terms at all times after reset.

Decomposition:
- Shared package pipe_pkg: typedef enum logic [1:0] skid_state_t {ST_EMPTY, ST_FULL, ST_SKID}.
- Sub-module sat_counter (parameter WIDTH; inputs clk, rst_n, i_inc; output o_count) implements the stall counter and is reusable for other performance counters.

Test Plan:
- Reset then i_valid=1, i_data=0xA5A5A5A5, i_ready=1 -> o_valid=1 with o_data=0xA5A5A5A5 next cycle; o_ready stays 1; o_occupancy=1.
- Stream 0x1,0x2,0x3 back-to-back; hold i_ready=0 on the cycle after 0x1 is captured -> 0x2 goes to skid, o_ready=0, o_occupancy=2; release i_ready -> outputs 0x1,0x2,0x3 in order, no loss, no duplicate.
- State SKID, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ready=1, o_occupancy=0; the incoming payload is never emitted.
- o_valid=1, i_ready=0 for 5 cycles with CNT_WIDTH=2 -> o_stall_count reads 1,2,3,3,3.
- SKID_EN=0, stage FULL, i_ready=1 and i_valid=1 with new 0x7 -> o_ready=1 combinationally, o_data=0x7 next cycle; with i_ready=0 -> o_ready=0.
- Drive rst_n=0 for one cycle while in SKID -> o_valid=0, o_data=0, o_stall_count=0; first accepted payload afterwards is delivered normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for pipeline-stage handshaking blocks.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_t;

    function automatic logic [1:0] occupancy(input skid_state_t s);
        logic [1:0] occ;
        case (s)
            ST_FULL: occ = 2'd1;
            ST_SKID: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-low reset; reusable for perf counters.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with flush, optional two-entry skid buffer
// (registered upstream ready) and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REG    = 1,
    parameter int unsigned SKID_EN    = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_flush,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [NUM_REG*DATA_WIDTH-1:0] i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [NUM_REG*DATA_WIDTH-1:0] o_data,
    output logic [1:0]                    o_occupancy,
    output logic [CNT_WIDTH-1:0]          o_stall_count
);

    localparam int unsigned PW = NUM_REG * DATA_WIDTH;

    skid_state_t     state_q, state_d;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q;
    logic            in_fire;
    logic            out_fire;

    assign o_valid     = (state_q != ST_EMPTY);
    assign o_occupancy = occupancy(state_q);
    assign o_data      = main_q;
    assign in_fire     = i_valid & o_ready;
    assign out_fire    = o_valid & i_ready;

    generate
        if (SKID_EN != 0) begin : g_skid
            logic          skid_load;
            logic [PW-1:0] skid_d;

            // Ready depends only on registered state, so no comb path from i_ready.
            assign o_ready   = rst_n & (state_q != ST_SKID);
            assign skid_load = !i_flush && (state_q == ST_FULL) && in_fire && !out_fire;
            assign skid_d    = skid_load ? i_data : skid_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    skid_q <= '0;
                end else begin
                    skid_q <= skid_d;
                end
            end
        end else begin : g_noskid
            assign o_ready = i_ready | (rst_n & ~o_valid);
            assign skid_q  = '0;
        end
    endgenerate

    // Next-state and main-register load; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_FULL;
                        main_d  = i_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = i_data;
                    end else if (in_fire) begin
                        state_d = (SKID_EN != 0) ? ST_SKID : ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (o_valid & ~i_ready),
        .o_count(o_stall_count)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vectors plus random traffic vs. a queue model.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (skid, 16-bit counter) and C (skid, 2-bit counter) share stimulus.
    logic        a_rst_n = 1'b0, a_flush = 1'b0, a_valid = 1'b0, a_ready = 1'b0;
    logic [31:0] a_data = '0;
    logic        a_o_ready, a_o_valid, c_o_ready, c_o_valid;
    logic [31:0] a_o_data, c_o_data;
    logic [1:0]  a_occ, c_occ;
    logic [15:0] a_stall;
    logic [1:0]  c_stall;

    // Instance B (no skid).
    logic        b_rst_n = 1'b0, b_flush = 1'b0, b_valid = 1'b0, b_ready = 1'b0;
    logic [31:0] b_data = '0;
    logic        b_o_ready, b_o_valid;
    logic [31:0] b_o_data;
    logic [1:0]  b_occ;
    logic [15:0] b_stall;

    pipe_stage_skid #(.DATA_WIDTH(32), .NUM_REG(1), .SKID_EN(1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .i_flush(a_flush), .i_valid(a_valid), .o_ready(a_o_ready),
        .i_data(a_data), .o_valid(a_o_valid), .i_ready(a_ready), .o_data(a_o_data),
        .o_occupancy(a_occ), .o_stall_count(a_stall));

    pipe_stage_skid #(.DATA_WIDTH(32), .NUM_REG(1), .SKID_EN(0), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .i_flush(b_flush), .i_valid(b_valid), .o_ready(b_o_ready),
        .i_data(b_data), .o_valid(b_o_valid), .i_ready(b_ready), .o_data(b_o_data),
        .o_occupancy(b_occ), .o_stall_count(b_stall));

    pipe_stage_skid #(.DATA_WIDTH(32), .NUM_REG(1), .SKID_EN(1), .CNT_WIDTH(2)) dut_c (
        .clk(clk), .rst_n(a_rst_n), .i_flush(a_flush), .i_valid(a_valid), .o_ready(c_o_ready),
        .i_data(a_data), .o_valid(c_o_valid), .i_ready(a_ready), .o_data(c_o_data),
        .o_occupancy(c_occ), .o_stall_count(c_stall));

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: per instance, an ordered list of held entries (front = output).
    int          m_occ[2];
    logic [31:0] m_ent[2][2];
    logic [31:0] m_last[2];
    int          m_cnt[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int k, input logic rst, input logic fl, input logic v,
                              input logic r, input logic [31:0] d);
        bit rdy, inf, outf;
        if (!rst) begin
            m_occ[k] = 0; m_last[k] = '0; m_cnt[k] = 0;
            return;
        end
        rdy  = (k == 0) ? (m_occ[k] < 2) : (r || m_occ[k] == 0);
        inf  = v && rdy;
        outf = (m_occ[k] > 0) && r;
        if (m_occ[k] > 0 && !r && m_cnt[k] < 65535) m_cnt[k]++;
        if (fl) begin
            m_occ[k] = 0;
        end else begin
            if (outf) begin
                m_ent[k][0] = m_ent[k][1];
                m_occ[k]--;
            end
            if (inf) begin
                m_ent[k][m_occ[k]] = d;
                m_occ[k]++;
            end
        end
        if (m_occ[k] > 0) m_last[k] = m_ent[k][0];
    endtask

    always @(posedge clk) begin
        model_edge(0, a_rst_n, a_flush, a_valid, a_ready, a_data);
        model_edge(1, b_rst_n, b_flush, b_valid, b_ready, b_data);
    end

    task automatic check_all();
        if (!chk_en) return;
        chk("a_valid", 64'(a_o_valid), 64'(m_occ[0] > 0));
        chk("a_ready", 64'(a_o_ready), 64'(a_rst_n && m_occ[0] < 2));
        chk("a_occ",   64'(a_occ),     64'(m_occ[0]));
        chk("a_data",  64'(a_o_data),  64'(m_last[0]));
        chk("a_stall", 64'(a_stall),   64'(m_cnt[0]));
        chk("c_stall", 64'(c_stall),   64'((m_cnt[0] > 3) ? 3 : m_cnt[0]));
        chk("b_valid", 64'(b_o_valid), 64'(m_occ[1] > 0));
        chk("b_ready", 64'(b_o_ready), 64'(b_ready || (b_rst_n && m_occ[1] == 0)));
        chk("b_occ",   64'(b_occ),     64'(m_occ[1]));
        chk("b_data",  64'(b_o_data),  64'(m_last[1]));
        chk("b_stall", 64'(b_stall),   64'(m_cnt[1]));
    endtask

    typedef struct {
        logic        rst, fl, v;
        logic [31:0] d;
        logic        r;
        logic        ev, er;
        logic [1:0]  eocc;
        logic [31:0] ed;
        int          ecnt, ecntc;
    } vec_t;

    function automatic vec_t mk(input logic rst, fl, v, input logic [31:0] d, input logic r,
                                input logic ev, er, input logic [1:0] eocc,
                                input logic [31:0] ed, input int ecnt, ecntc);
        vec_t t;
        t.rst = rst; t.fl = fl; t.v = v; t.d = d; t.r = r;
        t.ev = ev; t.er = er; t.eocc = eocc; t.ed = ed; t.ecnt = ecnt; t.ecntc = ecntc;
        return t;
    endfunction

    vec_t vt[22];

    initial begin
        //          rst fl v  data          r  ev er occ data          cnt c
        vt[0]  = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0, 0);
        vt[1]  = mk(1, 0, 1, 32'hA5A5A5A5, 1, 1, 1, 1, 32'hA5A5A5A5, 0, 0);
        vt[2]  = mk(1, 0, 0, 32'h0,        1, 0, 1, 0, 32'hA5A5A5A5, 0, 0);
        vt[3]  = mk(1, 0, 1, 32'h1,        1, 1, 1, 1, 32'h1,        0, 0);
        vt[4]  = mk(1, 0, 1, 32'h2,        0, 1, 0, 2, 32'h1,        1, 1);
        vt[5]  = mk(1, 0, 1, 32'h3,        1, 1, 1, 1, 32'h2,        1, 1);
        vt[6]  = mk(1, 0, 1, 32'h3,        1, 1, 1, 1, 32'h3,        1, 1);
        vt[7]  = mk(1, 0, 0, 32'h0,        1, 0, 1, 0, 32'h3,        1, 1);
        vt[8]  = mk(1, 0, 1, 32'h11,       0, 1, 1, 1, 32'h11,       1, 1);
        vt[9]  = mk(1, 0, 1, 32'h22,       0, 1, 0, 2, 32'h11,       2, 2);
        vt[10] = mk(1, 1, 1, 32'h33,       0, 0, 1, 0, 32'h11,       3, 3);
        vt[11] = mk(1, 0, 0, 32'h0,        1, 0, 1, 0, 32'h11,       3, 3);
        vt[12] = mk(1, 0, 1, 32'h44,       0, 1, 1, 1, 32'h44,       3, 3);
        vt[13] = mk(1, 0, 1, 32'h55,       0, 1, 0, 2, 32'h44,       4, 3);
        vt[14] = mk(0, 0, 1, 32'h66,       0, 0, 0, 0, 32'h0,        0, 0);
        vt[15] = mk(1, 0, 1, 32'h77,       0, 1, 1, 1, 32'h77,       0, 0);
        vt[16] = mk(1, 0, 0, 32'h0,        0, 1, 1, 1, 32'h77,       1, 1);
        vt[17] = mk(1, 0, 0, 32'h0,        0, 1, 1, 1, 32'h77,       2, 2);
        vt[18] = mk(1, 0, 0, 32'h0,        0, 1, 1, 1, 32'h77,       3, 3);
        vt[19] = mk(1, 0, 0, 32'h0,        0, 1, 1, 1, 32'h77,       4, 3);
        vt[20] = mk(1, 0, 0, 32'h0,        0, 1, 1, 1, 32'h77,       5, 3);
        vt[21] = mk(1, 0, 0, 32'h0,        1, 0, 1, 0, 32'h77,       5, 3);

        // Bring both stages out of an unknown state under reset.
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;

        // Directed vectors on the skid instance.
        for (int i = 0; i < 22; i++) begin
            a_rst_n = vt[i].rst; a_flush = vt[i].fl; a_valid = vt[i].v;
            a_data  = vt[i].d;   a_ready = vt[i].r;
            #1 check_all();
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(a_o_valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d_ready", i), 64'(a_o_ready), 64'(vt[i].er));
            chk($sformatf("vec%0d_occ", i),   64'(a_occ),     64'(vt[i].eocc));
            chk($sformatf("vec%0d_data", i),  64'(a_o_data),  64'(vt[i].ed));
            chk($sformatf("vec%0d_stall", i), 64'(a_stall),   64'(vt[i].ecnt));
            chk($sformatf("vec%0d_cstall", i), 64'(c_stall),  64'(vt[i].ecntc));
        end
        a_valid = 1'b0; a_ready = 1'b1;

        // Pass-through-ready instance: ready follows i_ready while full.
        b_rst_n = 1'b1; b_valid = 1'b1; b_data = 32'h5; b_ready = 1'b1;
        #1 check_all();
        chk("b_empty_ready", 64'(b_o_ready), 64'd1);
        @(negedge clk);
        chk("b_first_data", 64'(b_o_data), 64'h5);
        b_data = 32'h7;
        #1 check_all();
        chk("b_full_ready_hi", 64'(b_o_ready), 64'd1);
        @(negedge clk);
        chk("b_next_data", 64'(b_o_data), 64'h7);
        chk("b_next_valid", 64'(b_o_valid), 64'd1);
        b_data = 32'h8; b_ready = 1'b0;
        #1 check_all();
        chk("b_full_ready_lo", 64'(b_o_ready), 64'd0);
        @(negedge clk);
        chk("b_hold_data", 64'(b_o_data), 64'h7);
        b_valid = 1'b0; b_ready = 1'b1;
        #1 check_all();
        @(negedge clk);
        chk("b_drained", 64'(b_o_valid), 64'd0);

        // Random traffic on both instances against the model.
        for (int n = 0; n < 3000; n++) begin
            a_rst_n = ($urandom_range(99) != 0);
            a_flush = ($urandom_range(19) == 0);
            a_valid = ($urandom_range(9) < 6);
            a_ready = ($urandom_range(9) < 5);
            a_data  = $urandom;
            b_rst_n = ($urandom_range(99) != 0);
            b_flush = ($urandom_range(19) == 0);
            b_valid = ($urandom_range(9) < 6);
            b_ready = ($urandom_range(9) < 5);
            b_data  = $urandom;
            #1 check_all();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
